// File: rtl/tod_counter_if.sv
// Control, load, alarm and time/strobe bundle for the time-of-day counter.
// The master drives controls and loads; the slave is the counter itself.
interface tod_counter_if #(
    parameter int unsigned HOUR_W = 5,
    parameter int unsigned MS_W   = 6
);
    logic              run;
    logic              mode12;
    logic              ld_valid;
    logic [2:0]        ld_mask;
    logic [HOUR_W-1:0] ld_hour;
    logic [MS_W-1:0]   ld_min;
    logic [MS_W-1:0]   ld_sec;
    logic              alarm_en;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MS_W-1:0]   alarm_min;

    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   minute;
    logic [MS_W-1:0]   second;
    logic [HOUR_W-1:0] hour_disp;
    logic              pm;
    logic              sec_pulse;
    logic              min_pulse;
    logic              hour_pulse;
    logic              day_pulse;
    logic              ld_ack;
    logic              ld_err;
    logic              alarm_hit;

    modport master (
        output run, mode12, ld_valid, ld_mask, ld_hour, ld_min, ld_sec,
               alarm_en, alarm_hour, alarm_min,
        input  hour, minute, second, hour_disp, pm, sec_pulse, min_pulse,
               hour_pulse, day_pulse, ld_ack, ld_err, alarm_hit
    );

    modport slave (
        input  run, mode12, ld_valid, ld_mask, ld_hour, ld_min, ld_sec,
               alarm_en, alarm_hour, alarm_min,
        output hour, minute, second, hour_disp, pm, sec_pulse, min_pulse,
               hour_pulse, day_pulse, ld_ack, ld_err, alarm_hit
    );
endinterface

// File: rtl/tod_counter.sv
// Time-of-day counter: tick-enable divider, HH:MM:SS with carries, validated
// masked loads, 12/24-hour display, rollover strobes and an alarm compare.
module tod_counter #(
    parameter int unsigned CLK_DIV = 100000000,
    parameter int unsigned HOUR_W  = 5,
    parameter int unsigned MS_W    = 6
) (
    input  logic         clk,
    input  logic         rst,
    tod_counter_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
    localparam logic [HOUR_W-1:0] HOUR_12  = HOUR_W'(12);
    localparam logic [MS_W-1:0]   MS_MAX   = MS_W'(59);

    logic [DIV_W-1:0]  div_q,  div_n;
    logic [HOUR_W-1:0] hour_q, hour_n;
    logic [MS_W-1:0]   min_q,  min_n;
    logic [MS_W-1:0]   sec_q,  sec_n;
    logic sec_p_q,  sec_p_n;
    logic min_p_q,  min_p_n;
    logic hour_p_q, hour_p_n;
    logic day_p_q,  day_p_n;
    logic ack_q,    ack_n;
    logic err_q,    err_n;
    logic hit_q,    hit_n;

    logic tick;
    logic ld_bad;
    logic ld_take;

    assign tick    = bus.run && (div_q == DIV_LAST);
    assign ld_bad  = (bus.ld_mask[2] && (bus.ld_hour > HOUR_MAX)) ||
                     (bus.ld_mask[1] && (bus.ld_min  > MS_MAX))   ||
                     (bus.ld_mask[0] && (bus.ld_sec  > MS_MAX));
    assign ld_take = bus.ld_valid && !ld_bad;

    // Next-state: an accepted load wins over the tick; a rejected one lets it through.
    always_comb begin
        div_n    = div_q;
        hour_n   = hour_q;
        min_n    = min_q;
        sec_n    = sec_q;
        sec_p_n  = 1'b0;
        min_p_n  = 1'b0;
        hour_p_n = 1'b0;
        day_p_n  = 1'b0;
        ack_n    = 1'b0;
        err_n    = 1'b0;
        hit_n    = 1'b0;

        if (bus.run) begin
            div_n = tick ? '0 : div_q + DIV_W'(1);
        end

        if (ld_take) begin
            div_n = '0;
            ack_n = 1'b1;
            if (bus.ld_mask[2]) hour_n = bus.ld_hour;
            if (bus.ld_mask[1]) min_n  = bus.ld_min;
            if (bus.ld_mask[0]) sec_n  = bus.ld_sec;
        end else begin
            err_n = bus.ld_valid;
            if (tick) begin
                sec_p_n = 1'b1;
                if (sec_q == MS_MAX) begin
                    sec_n   = '0;
                    min_p_n = 1'b1;
                    if (min_q == MS_MAX) begin
                        min_n    = '0;
                        hour_p_n = 1'b1;
                        if (hour_q == HOUR_MAX) begin
                            hour_n  = '0;
                            day_p_n = 1'b1;
                        end else begin
                            hour_n = hour_q + HOUR_W'(1);
                        end
                    end else begin
                        min_n = min_q + MS_W'(1);
                    end
                end else begin
                    sec_n = sec_q + MS_W'(1);
                end
                // Only a tick can land on second 0, so this fires once per matching minute.
                hit_n = bus.alarm_en && (sec_n == '0) &&
                        (hour_n == bus.alarm_hour) && (min_n == bus.alarm_min);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            sec_p_q  <= 1'b0;
            min_p_q  <= 1'b0;
            hour_p_q <= 1'b0;
            day_p_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            div_q    <= div_n;
            hour_q   <= hour_n;
            min_q    <= min_n;
            sec_q    <= sec_n;
            sec_p_q  <= sec_p_n;
            min_p_q  <= min_p_n;
            hour_p_q <= hour_p_n;
            day_p_q  <= day_p_n;
            ack_q    <= ack_n;
            err_q    <= err_n;
            hit_q    <= hit_n;
        end
    end

    // Display hour is a pure decode of the registered 24-hour value.
    always_comb begin
        bus.hour_disp = hour_q;
        if (bus.mode12) begin
            if (hour_q == '0)          bus.hour_disp = HOUR_12;
            else if (hour_q > HOUR_12) bus.hour_disp = hour_q - HOUR_12;
        end
    end

    assign bus.pm         = (hour_q >= HOUR_12);
    assign bus.hour       = hour_q;
    assign bus.minute     = min_q;
    assign bus.second     = sec_q;
    assign bus.sec_pulse  = sec_p_q;
    assign bus.min_pulse  = min_p_q;
    assign bus.hour_pulse = hour_p_q;
    assign bus.day_pulse  = day_p_q;
    assign bus.ld_ack     = ack_q;
    assign bus.ld_err     = err_q;
    assign bus.alarm_hit  = hit_q;
endmodule

// File: tb/tb_tod_counter.sv
// Directed bench for tod_counter with CLK_DIV=4; expected values are hand-computed.
module tb_tod_counter;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MS_W   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    tod_counter_if #(.HOUR_W(HOUR_W), .MS_W(MS_W)) bus ();

    tod_counter #(.CLK_DIV(4), .HOUR_W(HOUR_W), .MS_W(MS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Flag order: {sec, min, hour, day, ack, err, alarm_hit}
    wire [16:0] tm = {bus.hour, bus.minute, bus.second};
    wire [6:0]  fl = {bus.sec_pulse, bus.min_pulse, bus.hour_pulse, bus.day_pulse,
                      bus.ld_ack, bus.ld_err, bus.alarm_hit};

    function automatic logic [16:0] tv(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [2:0] mask, input int h, input int m, input int s);
        bus.ld_valid = 1'b1;
        bus.ld_mask  = mask;
        bus.ld_hour  = 5'(h);
        bus.ld_min   = 6'(m);
        bus.ld_sec   = 6'(s);
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.run = 1'b1; bus.mode12 = 1'b0; bus.ld_valid = 1'b0; bus.ld_mask = 3'b000;
        bus.ld_hour = '0; bus.ld_min = '0; bus.ld_sec = '0;
        bus.alarm_en = 1'b0; bus.alarm_hour = '0; bus.alarm_min = '0;
        step(2);
        vectors++; if (tm !== tv(0,0,0)) begin miscompares++; $display("FAIL rst_time got %h exp %h", tm, tv(0,0,0)); end
        vectors++; if (fl !== 7'b0) begin miscompares++; $display("FAIL rst_flags got %b exp 0000000", fl); end
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd0, 1'b0}) begin miscompares++; $display("FAIL rst_disp24 got %0d/%b exp 0/0", bus.hour_disp, bus.pm); end
        bus.mode12 = 1'b1; #1;
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd12, 1'b0}) begin miscompares++; $display("FAIL rst_disp12 got %0d/%b exp 12/0", bus.hour_disp, bus.pm); end
        bus.mode12 = 1'b0;
        rst = 1'b0;
        step(3);
        vectors++; if (tm !== tv(0,0,0) || fl !== 7'b0) begin miscompares++; $display("FAIL pre_tick got %h/%b exp %h/0000000", tm, fl, tv(0,0,0)); end
        step(1);
        vectors++; if (tm !== tv(0,0,1) || fl !== 7'b1000000) begin miscompares++; $display("FAIL tick1 got %h/%b exp %h/1000000", tm, fl, tv(0,0,1)); end
        step(1);
        vectors++; if (fl !== 7'b0) begin miscompares++; $display("FAIL pulse_width got %b exp 0000000", fl); end
        step(3);
        vectors++; if (tm !== tv(0,0,2) || fl !== 7'b1000000) begin miscompares++; $display("FAIL tick2 got %h/%b exp %h/1000000", tm, fl, tv(0,0,2)); end
    endtask

    task automatic test_rollover;
        do_load(3'b111, 23, 59, 58);
        vectors++; if (tm !== tv(23,59,58) || fl !== 7'b0000100) begin miscompares++; $display("FAIL roll_load got %h/%b exp %h/0000100", tm, fl, tv(23,59,58)); end
        step(3);
        vectors++; if (tm !== tv(23,59,58)) begin miscompares++; $display("FAIL roll_hold got %h exp %h", tm, tv(23,59,58)); end
        step(1);
        vectors++; if (tm !== tv(23,59,59) || fl !== 7'b1000000) begin miscompares++; $display("FAIL roll_59 got %h/%b exp %h/1000000", tm, fl, tv(23,59,59)); end
        step(4);
        vectors++; if (tm !== tv(0,0,0) || fl !== 7'b1111000) begin miscompares++; $display("FAIL roll_day got %h/%b exp %h/1111000", tm, fl, tv(0,0,0)); end
        step(1);
        vectors++; if (fl !== 7'b0) begin miscompares++; $display("FAIL roll_after got %b exp 0000000", fl); end
    endtask

    task automatic test_load_rules;
        do_load(3'b111, 10, 20, 30);
        vectors++; if (tm !== tv(10,20,30) || fl !== 7'b0000100) begin miscompares++; $display("FAIL base_load got %h/%b exp %h/0000100", tm, fl, tv(10,20,30)); end
        do_load(3'b010, 0, 60, 0);
        vectors++; if (tm !== tv(10,20,30) || fl !== 7'b0000010) begin miscompares++; $display("FAIL bad_min got %h/%b exp %h/0000010", tm, fl, tv(10,20,30)); end
        step(2);
        do_load(3'b100, 13, 0, 0);
        vectors++; if (tm !== tv(13,20,30) || fl !== 7'b0000100) begin miscompares++; $display("FAIL load_vs_tick got %h/%b exp %h/0000100", tm, fl, tv(13,20,30)); end
        step(3);
        do_load(3'b001, 0, 0, 60);
        vectors++; if (tm !== tv(13,20,31) || fl !== 7'b1000010) begin miscompares++; $display("FAIL bad_in_tick got %h/%b exp %h/1000010", tm, fl, tv(13,20,31)); end
        step(1);
        do_load(3'b000, 1, 2, 3);
        vectors++; if (tm !== tv(13,20,31) || fl !== 7'b0000100) begin miscompares++; $display("FAIL mask0 got %h/%b exp %h/0000100", tm, fl, tv(13,20,31)); end
        step(3);
        vectors++; if (tm !== tv(13,20,31)) begin miscompares++; $display("FAIL mask0_div got %h exp %h", tm, tv(13,20,31)); end
        step(1);
        vectors++; if (tm !== tv(13,20,32) || fl !== 7'b1000000) begin miscompares++; $display("FAIL mask0_tick got %h/%b exp %h/1000000", tm, fl, tv(13,20,32)); end
    endtask

    task automatic test_mode12;
        bus.mode12 = 1'b1;
        do_load(3'b100, 0, 0, 0);
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd12, 1'b0}) begin miscompares++; $display("FAIL h0 got %0d/%b exp 12/0", bus.hour_disp, bus.pm); end
        do_load(3'b100, 12, 0, 0);
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd12, 1'b1}) begin miscompares++; $display("FAIL h12 got %0d/%b exp 12/1", bus.hour_disp, bus.pm); end
        do_load(3'b100, 13, 0, 0);
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd1, 1'b1}) begin miscompares++; $display("FAIL h13 got %0d/%b exp 1/1", bus.hour_disp, bus.pm); end
        do_load(3'b100, 23, 0, 0);
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd11, 1'b1}) begin miscompares++; $display("FAIL h23 got %0d/%b exp 11/1", bus.hour_disp, bus.pm); end
        bus.mode12 = 1'b0; #1;
        vectors++; if ({bus.hour_disp, bus.pm} !== {5'd23, 1'b1}) begin miscompares++; $display("FAIL h23_24 got %0d/%b exp 23/1", bus.hour_disp, bus.pm); end
    endtask

    task automatic test_alarm;
        bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30; bus.alarm_en = 1'b1;
        do_load(3'b111, 7, 29, 59);
        step(3);
        vectors++; if (bus.alarm_hit !== 1'b0) begin miscompares++; $display("FAIL alarm_early got %b exp 0", bus.alarm_hit); end
        step(1);
        vectors++; if (tm !== tv(7,30,0) || fl !== 7'b1100001) begin miscompares++; $display("FAIL alarm_hit got %h/%b exp %h/1100001", tm, fl, tv(7,30,0)); end
        step(1);
        vectors++; if (bus.alarm_hit !== 1'b0) begin miscompares++; $display("FAIL alarm_once got %b exp 0", bus.alarm_hit); end
        do_load(3'b111, 7, 30, 0);
        vectors++; if (fl !== 7'b0000100) begin miscompares++; $display("FAIL alarm_by_load got %b exp 0000100", fl); end
        step(4);
        vectors++; if (tm !== tv(7,30,1) || bus.alarm_hit !== 1'b0) begin miscompares++; $display("FAIL alarm_next_sec got %h/%b exp %h/0", tm, bus.alarm_hit, tv(7,30,1)); end
        bus.alarm_en = 1'b0;
        do_load(3'b111, 7, 29, 59);
        step(4);
        vectors++; if (tm !== tv(7,30,0) || fl !== 7'b1100000) begin miscompares++; $display("FAIL alarm_disabled got %h/%b exp %h/1100000", tm, fl, tv(7,30,0)); end
    endtask

    task automatic test_pause_and_reset;
        do_load(3'b111, 1, 2, 3);
        step(2);
        bus.run = 1'b0;
        step(10);
        vectors++; if (tm !== tv(1,2,3) || fl !== 7'b0) begin miscompares++; $display("FAIL paused got %h/%b exp %h/0000000", tm, fl, tv(1,2,3)); end
        bus.run = 1'b1;
        step(1);
        vectors++; if (tm !== tv(1,2,3)) begin miscompares++; $display("FAIL resume_hold got %h exp %h", tm, tv(1,2,3)); end
        step(1);
        vectors++; if (tm !== tv(1,2,4) || fl !== 7'b1000000) begin miscompares++; $display("FAIL resume_tick got %h/%b exp %h/1000000", tm, fl, tv(1,2,4)); end
        step(2);
        rst = 1'b1; #1;
        vectors++; if (tm !== tv(0,0,0) || fl !== 7'b0) begin miscompares++; $display("FAIL async_rst got %h/%b exp 0/0000000", tm, fl); end
        @(negedge clk);
        rst = 1'b0;
        step(3);
        vectors++; if (tm !== tv(0,0,0)) begin miscompares++; $display("FAIL rst_div got %h exp %h", tm, tv(0,0,0)); end
        step(1);
        vectors++; if (tm !== tv(0,0,1)) begin miscompares++; $display("FAIL rst_tick got %h exp %h", tm, tv(0,0,1)); end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_load_rules();
        test_mode12();
        test_alarm();
        test_pause_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish exp finish before 100000");
        $fatal(1);
    end
endmodule
